// File: rtl/fpu_pkg.sv
// Shared field extraction and special-value patterns for the parametrised FP add/sub path.
// Helpers take the field widths as arguments so one package serves every precision.
package fpu_pkg;

  localparam int GRD  = 2;
  localparam int MAXW = 64;

  typedef logic [MAXW-1:0] word_t;

  localparam word_t ZERO_PAT = '0;

  function automatic logic f_sign(input word_t w, input int exp_w, input int man_w);
    return 1'(w >> (exp_w + man_w));
  endfunction

  function automatic word_t f_exp(input word_t w, input int exp_w, input int man_w);
    return (w >> man_w) & ((word_t'(1) << exp_w) - word_t'(1));
  endfunction

  function automatic word_t f_frac(input word_t w, input int man_w);
    return w & ((word_t'(1) << man_w) - word_t'(1));
  endfunction

  function automatic word_t inf_pat(input logic s, input int exp_w, input int man_w);
    return (word_t'(s) << (exp_w + man_w)) | (((word_t'(1) << exp_w) - word_t'(1)) << man_w);
  endfunction

  // Positive quiet NaN: all-ones exponent with only the top fraction bit set.
  function automatic word_t qnan_pat(input int exp_w, input int man_w);
    return inf_pat(1'b0, exp_w, man_w) | (word_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
// No state, no handshake.
module fpu_lzc #(
  parameter int WIDTH = 27,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] cnt
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) cnt = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Pipelined FP add/sub (align -> add -> normalise), truncating, denormals flushed to zero.
// Latency 3 cycles at 1 op/clk; a held output stalls every stage (in_ready = !out_valid || out_ready).
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         overflow,
  output logic         underflow
);

  localparam int MW   = MAN_W + 1 + GRD;
  localparam int SW   = MW + 1;
  localparam int CW   = $clog2(SW + 1);
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef struct packed {
    logic             vld;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic             sgn_hi;
    logic             sgn_lo;
    logic [EXP_W-1:0] exp;
    logic [MW-1:0]    m_hi;
    logic [MW-1:0]    m_lo;
  } align_t;

  typedef struct packed {
    logic             vld;
    logic             spec;
    logic [W-1:0]     spec_res;
    logic             sgn;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sum;
  } add_t;

  logic   advance;
  align_t s1_d, s1_q;
  add_t   s2_d, s2_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic             sa, sb, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb, e_lo, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb, m_lo;

  always_comb begin
    sa    = f_sign(word_t'(a), EXP_W, MAN_W);
    sb    = f_sign(word_t'(b), EXP_W, MAN_W) ^ op;
    ea    = EXP_W'(f_exp(word_t'(a), EXP_W, MAN_W));
    eb    = EXP_W'(f_exp(word_t'(b), EXP_W, MAN_W));
    fa    = MAN_W'(f_frac(word_t'(a), MAN_W));
    fb    = MAN_W'(f_frac(word_t'(b), MAN_W));
    a_inf = &ea;
    b_inf = &eb;
    ma    = (ea == '0) ? '0 : {1'b1, fa, {GRD{1'b0}}};
    mb    = (eb == '0) ? '0 : {1'b1, fb, {GRD{1'b0}}};
    swap  = {eb, fb} > {ea, fa};

    s1_d        = '0;
    s1_d.vld    = in_valid;
    s1_d.sgn_hi = swap ? sb : sa;
    s1_d.sgn_lo = swap ? sa : sb;
    s1_d.exp    = swap ? eb : ea;
    s1_d.m_hi   = swap ? mb : ma;
    e_lo        = swap ? ea : eb;
    m_lo        = swap ? ma : mb;
    diff        = s1_d.exp - e_lo;
    s1_d.m_lo   = ({1'b0, diff} >= (EXP_W + 1)'(MW)) ? '0 : (m_lo >> diff);

    // Infinities bypass the datapath; opposite-signed infinities make a quiet NaN.
    s1_d.spec = a_inf || b_inf;
    if (a_inf && b_inf)
      s1_d.spec_res = (sa != sb) ? W'(qnan_pat(EXP_W, MAN_W)) : W'(inf_pat(sa, EXP_W, MAN_W));
    else if (a_inf)
      s1_d.spec_res = W'(inf_pat(sa, EXP_W, MAN_W));
    else if (b_inf)
      s1_d.spec_res = W'(inf_pat(sb, EXP_W, MAN_W));
  end

  always_comb begin
    s2_d          = '0;
    s2_d.vld      = s1_q.vld;
    s2_d.spec     = s1_q.spec;
    s2_d.spec_res = s1_q.spec_res;
    s2_d.sgn      = s1_q.sgn_hi;
    s2_d.exp      = s1_q.exp;
    if (s1_q.sgn_hi == s1_q.sgn_lo)
      s2_d.sum = {1'b0, s1_q.m_hi} + {1'b0, s1_q.m_lo};
    else
      s2_d.sum = {1'b0, s1_q.m_hi} - {1'b0, s1_q.m_lo};
  end

  logic [CW-1:0]    lz;
  logic [SW-1:0]    nrm_man;
  logic [MAN_W-1:0] nrm_frac;
  int               nrm_exp;
  logic [W-1:0]     res_d;
  logic             ovf_d, unf_d;

  fpu_lzc #(.WIDTH(SW), .CNT_W(CW)) u_lzc (
    .din (s2_q.sum),
    .cnt (lz)
  );

  // Target: hidden bit at SW-2; the top bit only ever holds an add carry.
  always_comb begin
    nrm_exp = int'(s2_q.exp);
    if (s2_q.sum[SW-1]) begin
      nrm_man = s2_q.sum >> 1;
      nrm_exp = nrm_exp + 1;
    end else begin
      nrm_man = s2_q.sum << (lz - CW'(1));
      nrm_exp = nrm_exp - int'(lz) + 1;
    end
    nrm_frac = MAN_W'(nrm_man >> GRD);

    res_d = W'(ZERO_PAT);
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s2_q.spec) begin
      res_d = s2_q.spec_res;
    end else if (s2_q.sum == '0) begin
      res_d = W'(ZERO_PAT);
    end else if (nrm_exp >= EMAX) begin
      res_d = {s2_q.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_d = s2_q.vld;
    end else if (nrm_exp < 1) begin
      unf_d = s2_q.vld;
    end else begin
      res_d = {s2_q.sgn, nrm_exp[EXP_W-1:0], nrm_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (advance) begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      out_valid <= s2_q.vld;
      result    <= res_d;
      overflow  <= ovf_d;
      underflow <= unf_d;
    end
  end

endmodule
